// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction fetch unit
//   fetch_entry_t : {pc, instr} pair carried through the instruction queue
//   ifetch_pc_t   : 32-bit byte program counter
//   INSTR_BYTES   : byte stride between sequential instructions
package ifetch_pkg;
  localparam int INSTR_BYTES = 4;
  typedef logic [31:0] ifetch_pc_t;
  typedef struct packed {
    ifetch_pc_t  pc;
    logic [31:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/program_memory_bus.sv
// program_memory_bus: word-read channel between fetch (consumer) and program memory
//   addr         : word index of the requested instruction
//   read_request : one read per asserted cycle
//   instr        : returned instruction word
//   data_valid   : instr is valid, a fixed latency after read_request
interface program_memory_bus;
  logic [31:0] addr;
  logic        read_request;
  logic [31:0] instr;
  logic        data_valid;
  modport CONSUMER (output addr, output read_request, input instr, input data_valid);
  modport PRODUCER (input addr, input read_request, output instr, output data_valid);
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous queue of fetch entries with flush and same-cycle push/pop
//   clk_in/rst_n_in : clock, asynchronous active-low reset
//   flush_in        : empty the queue (wins over push/pop)
//   push_in/push_data_in : enqueue an entry
//   pop_in          : dequeue the head (only when count_out != 0)
//   head_out        : head entry, read straight from the storage registers
//   count_out       : current occupancy
module fetch_fifo
  import ifetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   flush_in,
  input  logic                   push_in,
  input  fetch_entry_t           push_data_in,
  input  logic                   pop_in,
  output fetch_entry_t           head_out,
  output logic [$clog2(DEPTH):0] count_out
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_count;
  assign head_out  = r_mem[r_rd];
  assign count_out = r_count;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush_in) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (push_in) begin
        r_mem[r_wr] <= push_data_in;
        r_wr        <= r_wr + AW'(1);
      end
      if (pop_in) r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(push_in) - (AW+1)'(pop_in);
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC sequencing, credit-limited program memory reads, decode queue
//   clk_in/rst_n_in   : clock, asynchronous active-low reset
//   mem               : program_memory_bus consumer (addr/read_request out, instr/data_valid in)
//   redirect_valid_in : flush everything and restart fetch at redirect_pc_in
//   redirect_pc_in    : new byte PC (low two bits ignored)
//   instr_out/pc_out  : instruction at queue head and its byte PC
//   valid_out/ready_in: decode handshake
// Optional: define IFETCH_BYPASS_EN to forward a response straight to decode when
// the queue is empty and decode is ready, saving one cycle of latency.
module instruction_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          MEM_LATENCY = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  program_memory_bus.CONSUMER        mem,
  input  logic                       redirect_valid_in,
  input  logic [31:0]                redirect_pc_in,
  output logic [31:0]                instr_out,
  output logic [31:0]                pc_out,
  output logic                       valid_out,
  input  logic                       ready_in
);
  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(FIFO_DEPTH + MEM_LATENCY + 2);
  logic                   r_req;
  ifetch_pc_t             r_req_pc, r_pc;
  logic [MEM_LATENCY-1:0] r_live;
  ifetch_pc_t             r_tpc [MEM_LATENCY];
  logic [FW-1:0]          w_count;
  fetch_entry_t           w_head, w_resp;
  logic                   w_resp_live, w_bypass, w_fifo_valid, w_pop, w_push, w_issue;
  ifetch_pc_t             w_target, w_fetch_pc;
  logic [CW-1:0]          w_inflight, w_outstanding;
  assign w_target     = redirect_pc_in & ~ifetch_pc_t'(INSTR_BYTES - 1);
  assign w_fetch_pc   = redirect_valid_in ? w_target : r_pc;
  assign w_resp_live  = mem.data_valid & r_live[MEM_LATENCY-1];
  assign w_resp       = '{pc: r_tpc[MEM_LATENCY-1], instr: mem.instr};
  assign w_fifo_valid = w_count != '0;
`ifdef IFETCH_BYPASS_EN
  assign w_bypass = w_resp_live & ~w_fifo_valid & ready_in & ~redirect_valid_in;
`else
  assign w_bypass = 1'b0;
`endif
  assign w_pop          = w_fifo_valid & ready_in & ~redirect_valid_in;
  assign w_push         = w_resp_live & ~redirect_valid_in & ~w_bypass;
  assign valid_out      = ~redirect_valid_in & (w_fifo_valid | w_bypass);
  assign instr_out      = w_bypass ? w_resp.instr : w_head.instr;
  assign pc_out         = w_bypass ? w_resp.pc : w_head.pc;
  assign mem.addr         = {2'b00, r_req_pc[31:2]};
  assign mem.read_request = r_req;
  // Outstanding = queued after this cycle's pop + request on the bus + live tracker
  // stages. A tail response moves from tracker to queue, so the sum is conserved and
  // keeping it below FIFO_DEPTH before issuing means the queue can never overflow.
  // A redirect always issues its target: everything older is being discarded.
  always_comb begin
    w_inflight = CW'(r_req);
    for (int i = 0; i < MEM_LATENCY; i++) w_inflight = w_inflight + CW'(r_live[i]);
    w_outstanding = CW'(w_count) - CW'(w_pop | w_bypass) + w_inflight;
    w_issue       = redirect_valid_in | (w_outstanding < CW'(FIFO_DEPTH));
  end
  // r_req_pc is the registered bus request; r_pc is the next sequential PC to issue.
  // The tracker follows the bus request so its tail lines up with data_valid.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_req    <= 1'b0;
      r_req_pc <= RESET_PC;
      r_pc     <= RESET_PC;
      r_live   <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) r_tpc[i] <= '0;
    end else begin
      r_req <= w_issue;
      if (w_issue) begin
        r_req_pc <= w_fetch_pc;
        r_pc     <= w_fetch_pc + ifetch_pc_t'(INSTR_BYTES);
      end
      r_live[0] <= r_req & ~redirect_valid_in;
      r_tpc[0]  <= r_req_pc;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_live[i] <= r_live[i-1] & ~redirect_valid_in;
        r_tpc[i]  <= r_tpc[i-1];
      end
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .flush_in     (redirect_valid_in),
    .push_in      (w_push),
    .push_data_in (w_resp),
    .pop_in       (w_pop),
    .head_out     (w_head),
    .count_out    (w_count)
  );
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized and directed checks of instruction_fetch against a PC-stream model
module tb_instruction_fetch;
  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b1;
  logic        redirect_valid_in = 1'b0;
  logic [31:0] redirect_pc_in = '0;
  logic        ready_in = 1'b0;
  logic [31:0] instr_out, pc_out, instr2, pc2;
  logic        valid_out, valid2;
  logic        inject = 1'b0;
  logic        p1_v = 1'b0, q1_v = 1'b0;
  logic [31:0] p1_a = '0, q1_a = '0;
  int          errors = 0, checks = 0, hs = 0;
  logic [31:0] exp_pc = '0;

  program_memory_bus bus();
  program_memory_bus bus2();

  always #5 clk_in = ~clk_in;

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mem(bus),
    .redirect_valid_in(redirect_valid_in), .redirect_pc_in(redirect_pc_in),
    .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out), .ready_in(ready_in));

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .mem(bus2),
    .redirect_valid_in(1'b0), .redirect_pc_in(32'h0),
    .instr_out(instr2), .pc_out(pc2), .valid_out(valid2), .ready_in(1'b1));

  // Program memory: word n holds A000_0000+n, data returned two cycles after the request.
  always @(posedge clk_in) begin
    p1_v <= bus.read_request;
    p1_a <= bus.addr;
    bus.data_valid <= p1_v | inject;
    bus.instr <= 32'hA000_0000 + p1_a;
    q1_v <= bus2.read_request;
    q1_a <= bus2.addr;
    bus2.data_valid <= q1_v;
    bus2.instr <= 32'hA000_0000 + q1_a;
  end

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return 32'hA000_0000 + (pc >> 2);
  endfunction

  // One cycle: drive inputs after the falling edge, then score the decode stream.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] tgt);
    @(negedge clk_in);
    ready_in = rdy;
    redirect_valid_in = redir;
    redirect_pc_in = tgt;
    #1;
    if (redir) begin
      checks++;
      if (valid_out !== 1'b0) begin
        errors++;
        $display("FAIL redirect_valid: valid_out=%b required 0", valid_out);
      end
      exp_pc = tgt & ~32'd3;
    end else if (valid_out && ready_in) begin
      checks++;
      hs++;
      if (pc_out !== exp_pc || instr_out !== word_at(exp_pc)) begin
        errors++;
        $display("FAIL stream: pc_out=%h instr_out=%h required pc=%h instr=%h",
                 pc_out, instr_out, exp_pc, word_at(exp_pc));
      end
      exp_pc += 32'd4;
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst_n_in = 1'b0;
    ready_in = rdy;
    redirect_valid_in = 1'b0;
    inject = 1'b0;
    repeat (2) @(negedge clk_in);
    exp_pc = '0;
    rst_n_in = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    @(negedge clk_in);
    #1;
    checks += 6;
    if (bus.read_request !== 1'b0) begin errors++; $display("FAIL reset_req: %b required 0", bus.read_request); end
    if (bus.addr !== 32'h0) begin errors++; $display("FAIL reset_addr: %h required 0", bus.addr); end
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: %b required 0", valid_out); end
    if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr: %h required 0", instr_out); end
    if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: %h required 0", pc_out); end
    if (bus2.addr !== 32'h3FFF_FFFE) begin errors++; $display("FAIL reset_addr2: %h required 3ffffffe", bus2.addr); end
  endtask

  task automatic test_stream();
    int hs0;
    logic [31:0] p;
    do_reset(1'b1);
    hs0 = hs;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 32'h0);
      checks += 2;
      if (bus.read_request !== 1'b1 || bus.addr !== 32'(k)) begin
        errors++;
        $display("FAIL stream_req c%0d: req=%b addr=%h required 1 %h", k, bus.read_request, bus.addr, k);
      end
      if (valid_out !== (k >= 3)) begin
        errors++;
        $display("FAIL stream_valid c%0d: %b required %b", k, valid_out, k >= 3);
      end
      p = 32'hFFFF_FFF8 + 32'(4 * k);
      if (k < 4) begin
        checks++;
        if (bus2.addr !== (p >> 2)) begin errors++; $display("FAIL wrap_addr c%0d: %h required %h", k, bus2.addr, p >> 2); end
      end
      if (k >= 3 && k < 7) begin
        p = 32'hFFFF_FFF8 + 32'(4 * (k - 3));
        checks++;
        if (valid2 !== 1'b1 || pc2 !== p || instr2 !== word_at(p)) begin
          errors++;
          $display("FAIL wrap_out c%0d: v=%b pc=%h instr=%h required 1 %h %h", k, valid2, pc2, instr2, p, word_at(p));
        end
      end
    end
    checks++;
    if (hs - hs0 != 7) begin errors++; $display("FAIL stream_rate: %0d handshakes required 7", hs - hs0); end
  endtask

  task automatic test_stall();
    int reqs = 0;
    int hs0;
    do_reset(1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'h0);
      if (bus.read_request) reqs++;
    end
    checks += 2;
    if (reqs != 4) begin errors++; $display("FAIL stall_reqs: %0d required 4", reqs); end
    if (valid_out !== 1'b1 || pc_out !== 32'h0) begin errors++; $display("FAIL stall_head: v=%b pc=%h required 1 0", valid_out, pc_out); end
    hs0 = hs;
    for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 32'h0);
    checks++;
    if (hs - hs0 != 4 || exp_pc !== 32'h10) begin
      errors++;
      $display("FAIL stall_drain: %0d handshakes next_pc=%h required 4 00000010", hs - hs0, exp_pc);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] tgt;
    for (int s = 0; s < 2; s++) begin
      tgt = (s == 0) ? 32'h0000_0103 : 32'h0000_0202;
      do_reset(1'b1);
      repeat (6) step(s == 0, 1'b0, 32'h0);
      checks++;
      if (valid_out !== 1'b1) begin errors++; $display("FAIL redirect_pre s%0d: valid=%b required 1", s, valid_out); end
      step(1'b1, 1'b1, tgt);
      for (int k = 1; k <= 4; k++) begin
        step(1'b1, 1'b0, 32'h0);
        checks++;
        if (valid_out !== (k == 4)) begin
          errors++;
          $display("FAIL redirect_valid s%0d r+%0d: %b required %b", s, k, valid_out, k == 4);
        end
        if (k == 1) begin
          checks++;
          if (bus.read_request !== 1'b1 || bus.addr !== (tgt >> 2)) begin
            errors++;
            $display("FAIL redirect_req s%0d: req=%b addr=%h required 1 %h", s, bus.read_request, bus.addr, tgt >> 2);
          end
        end
        if (k == 4) begin
          checks++;
          if (pc_out !== (tgt & ~32'd3)) begin errors++; $display("FAIL redirect_pc s%0d: %h required %h", s, pc_out, tgt & ~32'd3); end
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset(1'b1);
    repeat (6) step(1'b1, 1'b0, 32'h0);
    rst_n_in = 1'b0;
    #1;
    checks++;
    if (bus.read_request !== 1'b0 || bus.addr !== 32'h0 || valid_out !== 1'b0 || instr_out !== 32'h0 || pc_out !== 32'h0) begin
      errors++;
      $display("FAIL midreset_outputs: req=%b addr=%h v=%b instr=%h pc=%h required 0 0 0 0 0",
               bus.read_request, bus.addr, valid_out, instr_out, pc_out);
    end
    inject = 1'b1;
    @(negedge clk_in);
    exp_pc = '0;
    rst_n_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 32'h0);
      if (k == 1) inject = 1'b0;
      checks++;
      if (valid_out !== (k == 3)) begin
        errors++;
        $display("FAIL midreset_valid c%0d: %b required %b", k, valid_out, k == 3);
      end
    end
    checks++;
    if (exp_pc !== 32'h4) begin errors++; $display("FAIL midreset_first: next_pc=%h required 00000004", exp_pc); end
  endtask

  task automatic test_random();
    int hs0;
    do_reset(1'b1);
    hs0 = hs;
    for (int k = 0; k < 400; k++) begin
      logic rdy;
      logic redir;
      rdy = $urandom_range(9) < 7;
      redir = $urandom_range(24) == 0;
      step(rdy, redir, $urandom);
    end
    repeat (8) step(1'b1, 1'b0, 32'h0);
    checks += 2;
    if (hs - hs0 < 100) begin errors++; $display("FAIL random_rate: %0d handshakes required >= 100", hs - hs0); end
    if (valid_out !== 1'b1) begin errors++; $display("FAIL random_drain: valid=%b required 1", valid_out); end
  endtask

  initial begin
    #2;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_reset_midstream();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Consumer-side master for `program_memory_bus`: keeps the program counter, issues word reads to program memory, and tracks the fixed 2-cycle memory latency. Returned instructions are queued in a small FIFO and handed to decode over a valid/ready handshake. Sits between program memory and the CPU decode stage. Discards in-flight fetches on a control-flow redirect, so the memory side never needs backpressure or cancellation.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, byte address fetched first after reset
- `FIFO_DEPTH`, 4, instruction queue entries (power of two, ≥ `MEM_LATENCY`)
- `MEM_LATENCY`, 2, cycles from `read_request` to `data_valid`

Ports:
- `clk_in` input 1: single clock
- `rst_n_in` input 1: reset, asynchronous, active-low
- `mem` modport `program_memory_bus.CONSUMER`: drives `addr` and `read_request`; receives `instr` and `data_valid`
- `redirect_valid_in` input 1: flush and restart fetch
- `redirect_pc_in` input 32: new byte PC
- `instr_out` output 32: instruction at head of queue
- `pc_out` output 32: byte PC of `instr_out`
- `valid_out` output 1: head entry valid
- `ready_in` input 1: decode accepts head

## Operation
- Fetch PC `pc` is a byte address.
  - `mem.addr = {2'b00, pc[31:2]}`, a word index.
  - `pc` increments by 4 per issued request and wraps from 32'hFFFF_FFFC to 0.
  - `redirect_pc_in[1:0]` is forced to 0.
- Credit rule:
  - Issue (`mem.read_request`=1) when `fifo_count + inflight_count < FIFO_DEPTH`, where `fifo_count` is after the current cycle's pop.
  - No redirect in the same cycle.
  - Guarantees FIFO never overflows.
- In-flight tracker: `MEM_LATENCY`-stage shift register of {live, pc}, loaded on every issue.
  - When `mem.data_valid`=1, the tail stage is consumed.
  - If the tail is live, {pc, `mem.instr`} is pushed to the FIFO. Otherwise the response is dropped.
  - `mem.data_valid` without a tail entry is a protocol error. Ignore it; see Configuration.
- Redirect (`redirect_valid_in`=1):
  - `pc <= redirect_pc_in & ~3`.
  - All tracker live bits clear. FIFO empties. No issue that cycle.
  - `valid_out` forced 0 that cycle, so any handshake in that cycle does not occur.
  - Fetch resumes next cycle.
- Pop occurs on `valid_out && ready_in`. Push and pop in the same cycle are allowed at any occupancy, including full and empty.
- Reset outputs: `mem.read_request`=0, `mem.addr`=`RESET_PC>>2`, `valid_out`=0, `instr_out`=0, `pc_out`=0. Tracker and FIFO are cleared, `pc`=`RESET_PC`.
- Reset asserted mid-operation: all state clears asynchronously. Responses arriving after reset release belong to no tracker entry and are dropped.

## Timing
- Reset release cycle 0: request for `RESET_PC`. Response at cycle 2, `valid_out`=1 at cycle 3.
- Steady state with `ready_in`=1: one instruction per cycle.
- Redirect at cycle r: first new request at r+1, new `valid_out` at r+4.
- With `ready_in`=0: issue stops after `FIFO_DEPTH` total outstanding entries (queued + in-flight). No response is ever lost.
- `mem.addr` and `mem.read_request` are registered. `valid_out`, `instr_out` and `pc_out` come from FIFO head registers.

## Configuration
- `IFETCH_BYPASS_EN`
  - Defined: a live response arriving while the FIFO is empty and `ready_in`=1 is presented combinationally on `instr_out`/`valid_out` in the same cycle, so fetch-to-decode latency is 2. Redirect still forces `valid_out`=0.
  - Undefined: all responses pass through the FIFO, latency 3.

## Structure
- `ifetch_pkg`:
  - `fetch_entry_t` {`logic[31:0] pc`, `logic[31:0] instr`}
  - `INSTR_BYTES`=4
  - `ifetch_pc_t`
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t`.
  - Depth `FIFO_DEPTH`.
  - Provides count output, flush input, and simultaneous push/pop.
  - Reset asynchronous, active-low.

## Test plan
- Reset release, `RESET_PC`=0, memory word n holds `32'hA000_0000+n`, `ready_in`=1 → `pc_out` 0, 4, 8, … with `instr_out` A000_0000, A000_0001, …, first valid at cycle 3, one per cycle.
- `ready_in`=0 for 10 cycles → exactly 4 requests issued, 4 entries held. After `ready_in`=1, entries at pc 0, 4, 8, 12 appear in order; nothing lost or duplicated.
- Redirect to 32'h0000_0103 while 2 requests are in flight → both dropped, next `pc_out`=32'h100, valid at r+4.
- Redirect in the same cycle as `valid_out && ready_in` → no handshake counted; FIFO empty next cycle.
- `RESET_PC`=32'hFFFF_FFF8 → `pc_out` FFFF_FFF8, FFFF_FFFC, 0, 4, with `mem.addr` wrapping accordingly.
- Assert `rst_n_in` low mid-stream with 2 requests in flight → outputs take reset values immediately. Late `data_valid` pulses after release produce no `valid_out`.
